// File: rtl/bilinear_pkg.sv
// Shared types and elaboration-time helpers for the bilinear upscaler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: scan FSM state enum, fixed-point step function, width helpers
// and default geometry so the datapath and the sequencer agree on widths.
package bilinear_pkg;

   // Default geometry (overridable per instance).
   localparam int H_IN_D    = 256;
   localparam int W_IN_D    = 256;
   localparam int H_OUT_D   = 1024;
   localparam int W_OUT_D   = 1024;
   localparam int CHANNEL_D = 3;
   localparam int FRAC_W_D  = 8;
   localparam int ADDR_W_D  = 18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } scan_state_e;

   // Width able to index 0..n-1, never narrower than one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Source-coordinate increment per output step, FRAC_W fractional bits.
   function automatic int calc_step(input int n_in, input int n_out, input int frac_w);
      return (n_in << frac_w) / n_out;
   endfunction

   localparam int X_OUT_W_D = width_of(W_OUT_D);
   localparam int Y_OUT_W_D = width_of(H_OUT_D);
   localparam int CH_W_D    = width_of(CHANNEL_D);
   localparam int X_IN_W_D  = width_of(W_IN_D);
   localparam int Y_IN_W_D  = width_of(H_IN_D);

endpackage

// File: rtl/bilinear_axis_step.sv
// One axis of the source-coordinate walk: fixed-point accumulator split into
// integer neighbours (idx0, clamped idx1) and fractional weight.
// Latency: outputs are combinational and describe the accumulator value that
// will be held after the coming clock edge; backpressure: none, the caller
// only pulses advance/clear when its own request is accepted.
//
// Ports:
//   clk_i, rst_ni  clock, async active-low reset (accumulator -> 0)
//   clear_i        zero the accumulator (has priority over advance_i)
//   advance_i      add STEP to the accumulator
//   idx0_o         integer part of the next accumulator value
//   idx1_o         idx0_o + 1, clamped to N_IN-1
//   frac_o         fractional part of the next accumulator value
module bilinear_axis_step
   import bilinear_pkg::*;
#(
   parameter int N_IN   = 256,
   parameter int N_OUT  = 1024,
   parameter int FRAC_W = 8,
   parameter int IDX_W  = width_of(N_IN)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              advance_i,
   output logic [IDX_W-1:0]  idx0_o,
   output logic [IDX_W-1:0]  idx1_o,
   output logic [FRAC_W-1:0] frac_o
);

   localparam int ACC_W = IDX_W + FRAC_W;
   localparam logic [ACC_W-1:0] STEP     = ACC_W'(calc_step(N_IN, N_OUT, FRAC_W));
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

   logic [ACC_W-1:0] acc_q, acc_d;

   // The largest value ever reached is (N_OUT-1)*STEP, which stays below
   // N_IN<<FRAC_W, so the integer part never exceeds N_IN-1.
   always_comb begin
      acc_d = acc_q;
      if (clear_i) begin
         acc_d = '0;
      end else if (advance_i) begin
         acc_d = acc_q + STEP;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // Exposing the next value lets the caller register the neighbour indices
   // in the same edge as the rest of the request, keeping start latency at 1.
   assign idx0_o = acc_d[ACC_W-1:FRAC_W];
   assign idx1_o = (idx0_o == IDX_LAST) ? idx0_o : idx0_o + IDX_W'(1);
   assign frac_o = acc_d[FRAC_W-1:0];

endmodule

// File: rtl/bilinear_scan_ctrl.sv
// Raster sequencer for the bilinear upscaler: one request (4 neighbour
// addresses + fx/fy) per output pixel channel, channel innermost.
// Latency: first request valid the cycle after an accepted start, then one
// request per cycle; backpressure: all request fields hold while !req_ready_i.
//
// Optional build macro SCAN_PERF_EN adds stall_cnt_o (32-bit count of cycles
// with req_valid_o && !req_ready_i; cleared on start, saturating).
//
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   start_i            begin a frame (sampled only in IDLE)
//   busy_o, done_o     frame in progress / one-cycle end-of-frame pulse
//   req_valid_o        request handshake valid, req_ready_i accept
//   x_out_o, y_out_o   output pixel coordinate, ch_o channel index
//   addr00..addr11_o   source addresses (y0,x0),(y0,x1),(y1,x0),(y1,x1)
//   fx_o, fy_o         horizontal / vertical fractional weights
//   last_o             current request is the final one of the frame
module bilinear_scan_ctrl
   import bilinear_pkg::*;
#(
   parameter int H_IN    = H_IN_D,
   parameter int W_IN    = W_IN_D,
   parameter int H_OUT   = H_OUT_D,
   parameter int W_OUT   = W_OUT_D,
   parameter int CHANNEL = CHANNEL_D,
   parameter int FRAC_W  = FRAC_W_D,
   parameter int ADDR_W  = ADDR_W_D
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         start_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         req_valid_o,
   input  logic                         req_ready_i,
   output logic [width_of(W_OUT)-1:0]   x_out_o,
   output logic [width_of(H_OUT)-1:0]   y_out_o,
   output logic [width_of(CHANNEL)-1:0] ch_o,
   output logic [ADDR_W-1:0]            addr00_o,
   output logic [ADDR_W-1:0]            addr01_o,
   output logic [ADDR_W-1:0]            addr10_o,
   output logic [ADDR_W-1:0]            addr11_o,
   output logic [FRAC_W-1:0]            fx_o,
   output logic [FRAC_W-1:0]            fy_o,
   output logic                         last_o
`ifdef SCAN_PERF_EN
   ,
   output logic [31:0]                  stall_cnt_o
`endif
);

   localparam int X_W  = width_of(W_OUT);
   localparam int Y_W  = width_of(H_OUT);
   localparam int CH_W = width_of(CHANNEL);
   localparam int XI_W = width_of(W_IN);
   localparam int YI_W = width_of(H_IN);

   localparam logic [X_W-1:0]    X_LAST  = X_W'(W_OUT - 1);
   localparam logic [Y_W-1:0]    Y_LAST  = Y_W'(H_OUT - 1);
   localparam logic [CH_W-1:0]   CH_LAST = CH_W'(CHANNEL - 1);
   localparam logic [ADDR_W-1:0] ROW_MUL = ADDR_W'(W_IN * CHANNEL);
   localparam logic [ADDR_W-1:0] COL_MUL = ADDR_W'(CHANNEL);

   scan_state_e state_q, state_d;

   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic              vld_q, vld_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              last_q, last_d;
   logic [FRAC_W-1:0] fx_q, fx_d, fy_q, fy_d;
   logic [ADDR_W-1:0] a00_q, a00_d, a01_q, a01_d, a10_q, a10_d, a11_q, a11_d;

   logic              hs;
   logic              load;
   logic              x_clr, x_adv, y_clr, y_adv;
   logic [XI_W-1:0]   x0_n, x1_n;
   logic [YI_W-1:0]   y0_n, y1_n;
   logic [FRAC_W-1:0] fx_n, fy_n;

   // Both multipliers are elaboration constants, so these reduce to
   // shift-and-add trees rather than general multipliers.
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [YI_W-1:0] row,
                                                  input logic [XI_W-1:0] col,
                                                  input logic [CH_W-1:0] chn);
      return ADDR_W'(row) * ROW_MUL + ADDR_W'(col) * COL_MUL + ADDR_W'(chn);
   endfunction

   bilinear_axis_step #(
      .N_IN   (W_IN),
      .N_OUT  (W_OUT),
      .FRAC_W (FRAC_W),
      .IDX_W  (XI_W)
   ) u_axis_x (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (x_clr),
      .advance_i (x_adv),
      .idx0_o    (x0_n),
      .idx1_o    (x1_n),
      .frac_o    (fx_n)
   );

   bilinear_axis_step #(
      .N_IN   (H_IN),
      .N_OUT  (H_OUT),
      .FRAC_W (FRAC_W),
      .IDX_W  (YI_W)
   ) u_axis_y (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (y_clr),
      .advance_i (y_adv),
      .idx0_o    (y0_n),
      .idx1_o    (y1_n),
      .frac_o    (fy_n)
   );

   assign hs = vld_q && req_ready_i;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      ch_d    = ch_q;
      vld_d   = vld_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      last_d  = last_q;
      fx_d    = fx_q;
      fy_d    = fy_q;
      a00_d   = a00_q;
      a01_d   = a01_q;
      a10_d   = a10_q;
      a11_d   = a11_q;
      load    = 1'b0;
      x_clr   = 1'b0;
      x_adv   = 1'b0;
      y_clr   = 1'b0;
      y_adv   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
               x_d     = '0;
               y_d     = '0;
               ch_d    = '0;
               x_clr   = 1'b1;
               y_clr   = 1'b1;
               vld_d   = 1'b1;
               busy_d  = 1'b1;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (hs) begin
               if (last_q) begin
                  state_d = DONE;
                  vld_d   = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  last_d  = 1'b0;
               end else begin
                  load = 1'b1;
                  if (ch_q == CH_LAST) begin
                     ch_d = '0;
                     if (x_q == X_LAST) begin
                        x_d   = '0;
                        x_clr = 1'b1;
                        y_d   = y_q + Y_W'(1);
                        y_adv = 1'b1;
                     end else begin
                        x_d   = x_q + X_W'(1);
                        x_adv = 1'b1;
                     end
                  end else begin
                     ch_d = ch_q + CH_W'(1);
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Axis outputs already reflect this cycle's clear/advance, so the
      // whole request is captured coherently in one edge.
      if (load) begin
         fx_d   = fx_n;
         fy_d   = fy_n;
         a00_d  = pix_addr(y0_n, x0_n, ch_d);
         a01_d  = pix_addr(y0_n, x1_n, ch_d);
         a10_d  = pix_addr(y1_n, x0_n, ch_d);
         a11_d  = pix_addr(y1_n, x1_n, ch_d);
         last_d = (ch_d == CH_LAST) && (x_d == X_LAST) && (y_d == Y_LAST);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         ch_q    <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         last_q  <= 1'b0;
         fx_q    <= '0;
         fy_q    <= '0;
         a00_q   <= '0;
         a01_q   <= '0;
         a10_q   <= '0;
         a11_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ch_q    <= ch_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         last_q  <= last_d;
         fx_q    <= fx_d;
         fy_q    <= fy_d;
         a00_q   <= a00_d;
         a01_q   <= a01_d;
         a10_q   <= a10_d;
         a11_q   <= a11_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign req_valid_o = vld_q;
   assign x_out_o     = x_q;
   assign y_out_o     = y_q;
   assign ch_o        = ch_q;
   assign addr00_o    = a00_q;
   assign addr01_o    = a01_q;
   assign addr10_o    = a10_q;
   assign addr11_o    = a11_q;
   assign fx_o        = fx_q;
   assign fy_o        = fy_q;
   assign last_o      = last_q;

`ifdef SCAN_PERF_EN
   logic [31:0] stall_q, stall_d;

   // Only counts while a request is actually offered; since req_valid is
   // low after done the value naturally holds until the next start.
   always_comb begin
      stall_d = stall_q;
      if (state_q == IDLE && start_i) begin
         stall_d = '0;
      end else if (vld_q && !req_ready_i && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_bilinear_scan_ctrl.sv
// Bench for bilinear_scan_ctrl: two 4x4 -> 8x8 instances (1 and 3 channels),
// a per-cycle model comparison on each, and directed literal checks on
// clamping, address math, backpressure, frame length, done/busy and reset.
module tb_bilinear_scan_ctrl;

   localparam int STEP = (4 * 256) / 8;   // 128

   typedef struct {
      int vld; int busy; int done; int x; int y; int ch;
      int a00; int a01; int a10; int a11; int fx; int fy; int last;
   } rq_t;

   logic clk, rst_n;
   logic start1, rdy1, start3, rdy3;

   logic       d1_busy, d1_done, d1_vld, d1_last;
   logic [2:0] d1_x, d1_y;
   logic [0:0] d1_ch;
   logic [7:0] d1_a00, d1_a01, d1_a10, d1_a11, d1_fx, d1_fy;

   logic       d3_busy, d3_done, d3_vld, d3_last;
   logic [2:0] d3_x, d3_y;
   logic [1:0] d3_ch;
   logic [7:0] d3_a00, d3_a01, d3_a10, d3_a11, d3_fx, d3_fy;

`ifdef SCAN_PERF_EN
   logic [31:0] d1_stall, d3_stall;
`endif

   int total, bad;
   int idx1, idx3, len1, len3, dn1, dn3;

   bilinear_scan_ctrl #(
      .H_IN(4), .W_IN(4), .H_OUT(8), .W_OUT(8), .CHANNEL(1), .FRAC_W(8), .ADDR_W(8)
   ) u_d1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .busy_o(d1_busy), .done_o(d1_done),
      .req_valid_o(d1_vld), .req_ready_i(rdy1), .x_out_o(d1_x), .y_out_o(d1_y), .ch_o(d1_ch),
      .addr00_o(d1_a00), .addr01_o(d1_a01), .addr10_o(d1_a10), .addr11_o(d1_a11),
      .fx_o(d1_fx), .fy_o(d1_fy), .last_o(d1_last)
`ifdef SCAN_PERF_EN
      , .stall_cnt_o(d1_stall)
`endif
   );

   bilinear_scan_ctrl #(
      .H_IN(4), .W_IN(4), .H_OUT(8), .W_OUT(8), .CHANNEL(3), .FRAC_W(8), .ADDR_W(8)
   ) u_d3 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start3), .busy_o(d3_busy), .done_o(d3_done),
      .req_valid_o(d3_vld), .req_ready_i(rdy3), .x_out_o(d3_x), .y_out_o(d3_y), .ch_o(d3_ch),
      .addr00_o(d3_a00), .addr01_o(d3_a01), .addr10_o(d3_a10), .addr11_o(d3_a11),
      .fx_o(d3_fx), .fy_o(d3_fy), .last_o(d3_last)
`ifdef SCAN_PERF_EN
      , .stall_cnt_o(d3_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected request number k of a frame: raster order, channel innermost,
   // source position = output position * STEP in 8-bit fixed point.
   function automatic rq_t model(input int k, input int c);
      rq_t r;
      int ax, ay, x0, x1, y0, y1;
      r.ch = k % c;
      r.x  = (k / c) % 8;
      r.y  = k / (c * 8);
      ax = r.x * STEP;
      ay = r.y * STEP;
      x0 = ax / 256;
      y0 = ay / 256;
      x1 = (x0 + 1 > 3) ? 3 : x0 + 1;
      y1 = (y0 + 1 > 3) ? 3 : y0 + 1;
      r.fx   = ax % 256;
      r.fy   = ay % 256;
      r.a00  = (y0 * 4 + x0) * c + r.ch;
      r.a01  = (y0 * 4 + x1) * c + r.ch;
      r.a10  = (y1 * 4 + x0) * c + r.ch;
      r.a11  = (y1 * 4 + x1) * c + r.ch;
      r.last = (k == 64 * c - 1) ? 1 : 0;
      r.vld  = 1;
      r.busy = 1;
      r.done = 0;
      return r;
   endfunction

   task automatic sample(input int sel, output rq_t r);
      if (sel == 1) begin
         r.vld = int'(d1_vld); r.busy = int'(d1_busy); r.done = int'(d1_done);
         r.x = int'(d1_x); r.y = int'(d1_y); r.ch = int'(d1_ch);
         r.a00 = int'(d1_a00); r.a01 = int'(d1_a01); r.a10 = int'(d1_a10); r.a11 = int'(d1_a11);
         r.fx = int'(d1_fx); r.fy = int'(d1_fy); r.last = int'(d1_last);
      end else begin
         r.vld = int'(d3_vld); r.busy = int'(d3_busy); r.done = int'(d3_done);
         r.x = int'(d3_x); r.y = int'(d3_y); r.ch = int'(d3_ch);
         r.a00 = int'(d3_a00); r.a01 = int'(d3_a01); r.a10 = int'(d3_a10); r.a11 = int'(d3_a11);
         r.fx = int'(d3_fx); r.fy = int'(d3_fy); r.last = int'(d3_last);
      end
   endtask

   task automatic cmp_model(input string tag, input int sel, input int k, input int c);
      rq_t a, e;
      sample(sel, a);
      e = model(k, c);
      chk({tag, ".busy"}, a.busy, e.busy);
      chk({tag, ".done"}, a.done, e.done);
      chk({tag, ".x"},    a.x,    e.x);
      chk({tag, ".y"},    a.y,    e.y);
      chk({tag, ".ch"},   a.ch,   e.ch);
      chk({tag, ".a00"},  a.a00,  e.a00);
      chk({tag, ".a01"},  a.a01,  e.a01);
      chk({tag, ".a10"},  a.a10,  e.a10);
      chk({tag, ".a11"},  a.a11,  e.a11);
      chk({tag, ".fx"},   a.fx,   e.fx);
      chk({tag, ".fy"},   a.fy,   e.fy);
      chk({tag, ".last"}, a.last, e.last);
   endtask

   task automatic chk_zero(input string tag, input int sel);
      rq_t a;
      sample(sel, a);
      chk({tag, ".vld"},  a.vld,  0);
      chk({tag, ".busy"}, a.busy, 0);
      chk({tag, ".done"}, a.done, 0);
      chk({tag, ".x"},    a.x,    0);
      chk({tag, ".y"},    a.y,    0);
      chk({tag, ".ch"},   a.ch,   0);
      chk({tag, ".a00"},  a.a00,  0);
      chk({tag, ".a01"},  a.a01,  0);
      chk({tag, ".a10"},  a.a10,  0);
      chk({tag, ".a11"},  a.a11,  0);
      chk({tag, ".fx"},   a.fx,   0);
      chk({tag, ".fy"},   a.fy,   0);
      chk({tag, ".last"}, a.last, 0);
   endtask

   // Directed checks and input changes happen 2 time units after posedge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_frame(input int sel);
      if (sel == 1) start1 = 1'b1; else start3 = 1'b1;
      tick();
      start1 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic wait_req(input string nm, input int sel, input int x, input int y,
                           input int ch, input int lim);
      rq_t r;
      int found = 0;
      for (int i = 0; i < lim && found == 0; i++) begin
         sample(sel, r);
         if (r.vld == 1 && r.x == x && r.y == y && r.ch == ch) found = 1;
         else tick();
      end
      chk({nm, ".reached"}, found, 1);
   endtask

   task automatic wait_done(input string nm, input int sel, input int lim);
      rq_t r;
      int found = 0;
      for (int i = 0; i < lim && found == 0; i++) begin
         sample(sel, r);
         if (r.done == 1) found = 1;
         else tick();
      end
      chk({nm, ".done_seen"}, found, 1);
   endtask

   initial begin
      rq_t r;
      total = 0; bad = 0;
      idx1 = 0; idx3 = 0; len1 = 0; len3 = 0; dn1 = 0; dn3 = 0;
      rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; rdy1 = 1'b1; rdy3 = 1'b1;

      // Scoreboard: every valid cycle is checked against the model; the
      // request index advances on each handshake and restarts between frames.
      fork
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               idx1 = 0;
               idx3 = 0;
            end else begin
               if (d1_done) begin len1 = idx1; dn1 = dn1 + 1; end
               if (d1_vld) begin
                  cmp_model("m1", 1, idx1, 1);
                  if (rdy1) idx1 = idx1 + 1;
               end else idx1 = 0;
               if (d3_done) begin len3 = idx3; dn3 = dn3 + 1; end
               if (d3_vld) begin
                  cmp_model("m3", 3, idx3, 3);
                  if (rdy3) idx3 = idx3 + 1;
               end else idx3 = 0;
            end
         end
      join_none

      // Reset state
      tick();
      chk_zero("rst_d1", 1);
      chk_zero("rst_d3", 3);
      rst_n = 1'b1;
      tick();
      tick();

      // Frame 1, CHANNEL=1, ready high
      start_frame(1);
      sample(1, r);
      chk("a_first.vld",  r.vld,  1);
      chk("a_first.busy", r.busy, 1);
      chk("a_first.x",    r.x,    0);
      chk("a_first.a01",  r.a01,  1);
      chk("a_first.a10",  r.a10,  4);
      chk("a_first.a11",  r.a11,  5);
      wait_req("a_x3", 1, 3, 0, 0, 20);
      sample(1, r);
      chk("a_x3.fx",  r.fx,  128);
      chk("a_x3.a00", r.a00, 1);
      chk("a_x3.a01", r.a01, 2);
      chk("a_x3.a11", r.a11, 6);
      wait_req("a_x7", 1, 7, 0, 0, 20);
      sample(1, r);
      chk("a_x7.a00", r.a00, 3);
      chk("a_x7.a01", r.a01, 3);
      chk("a_x7.a10", r.a10, 7);
      chk("a_x7.a11", r.a11, 7);
      wait_req("a_end", 1, 7, 7, 0, 80);
      sample(1, r);
      chk("a_end.a00",  r.a00,  15);
      chk("a_end.a11",  r.a11,  15);
      chk("a_end.fy",   r.fy,   128);
      chk("a_end.last", r.last, 1);
      tick();
      sample(1, r);
      chk("a_done.done", r.done, 1);
      chk("a_done.busy", r.busy, 0);
      chk("a_done.vld",  r.vld,  0);
      tick();
      sample(1, r);
      chk("a_after.done", r.done, 0);
      chk("a_len", len1, 64);
      chk("a_dn",  dn1,  1);

      // Frame 2, CHANNEL=1, 5 cycles of backpressure on request (2,1)
      start_frame(1);
      wait_req("b_hold", 1, 2, 1, 0, 30);
      rdy1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         sample(1, r);
         chk("b_hold.vld", r.vld, 1);
         chk("b_hold.x",   r.x,   2);
         chk("b_hold.y",   r.y,   1);
         chk("b_hold.a00", r.a00, 1);
         chk("b_hold.a01", r.a01, 2);
         chk("b_hold.a10", r.a10, 5);
         chk("b_hold.a11", r.a11, 6);
         chk("b_hold.fx",  r.fx,  0);
         chk("b_hold.fy",  r.fy,  128);
      end
      rdy1 = 1'b1;
      wait_done("b", 1, 100);
      tick();
      chk("b_len", len1, 64);
      chk("b_dn",  dn1,  2);
`ifdef SCAN_PERF_EN
      chk("b_stall", int'(d1_stall), 5);
`endif

      // Frame on the 3-channel instance
      start_frame(3);
      wait_req("c_x2", 3, 2, 0, 0, 30);
      sample(3, r);
      chk("c_x2c0.a00", r.a00, 3);
      chk("c_x2c0.fx",  r.fx,  0);
      tick();
      sample(3, r);
      chk("c_x2c1.ch",  r.ch,  1);
      chk("c_x2c1.a00", r.a00, 4);
      tick();
      sample(3, r);
      chk("c_x2c2.ch",  r.ch,  2);
      chk("c_x2c2.a00", r.a00, 5);
      chk("c_x2c2.a11", r.a11, 20);
      tick();
      sample(3, r);
      chk("c_x3.x",   r.x,   3);
      chk("c_x3.ch",  r.ch,  0);
      chk("c_x3.a00", r.a00, 3);
      chk("c_x3.a01", r.a01, 6);
      chk("c_x3.fx",  r.fx,  128);
      wait_done("c", 3, 250);
      tick();
      chk("c_len", len3, 192);
      chk("c_dn",  dn3,  1);

      // Reset during the 10th request, then a clean frame with stray starts
      start_frame(1);
      wait_req("d_k9", 1, 1, 1, 0, 30);
      rst_n = 1'b0;
      #1;
      chk_zero("d_rst", 1);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("d_nodone", dn1, 2);
      start_frame(1);
      sample(1, r);
      chk("d_first.vld", r.vld, 1);
      chk("d_first.x",   r.x,   0);
      chk("d_first.y",   r.y,   0);
      chk("d_first.ch",  r.ch,  0);
      for (int i = 0; i < 5; i++) tick();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      start1 = 1'b1;
      tick();
      tick();
      start1 = 1'b0;
      wait_done("d", 1, 100);
      tick();
      chk("d_len", len1, 64);
      chk("d_dn",  dn1,  3);
      for (int i = 0; i < 3; i++) tick();
      sample(1, r);
      chk("d_idle.vld",  r.vld,  0);
      chk("d_idle.busy", r.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bilinear_scan_ctrl.md
Name: bilinear_scan_ctrl

Overview:
- Sequencer for the bilinear upscaler datapath: walks output pixels in raster order, channel innermost.
- For each step it issues the four neighbour source addresses plus fractional weights to the interpolation datapath over a valid/ready handshake.
- Replaces the ad-hoc coordinate counters inside the top-level FSM; the top level drives start and consumes done/busy.

Parameters:
H_IN, 256, input image height
W_IN, 256, input image width
H_OUT, 1024, output image height
W_OUT, 1024, output image width
CHANNEL, 3, channels per pixel, interleaved in memory
FRAC_W, 8, fractional bits of source coordinate and weights
ADDR_W, 18, input-memory address width, must hold H_IN*W_IN*CHANNEL-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin a frame; sampled only in IDLE
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after final handshake
req_valid  out  1  request fields valid
req_ready  in  1  datapath accepts request
x_out  out  clog2(W_OUT)  output column
y_out  out  clog2(H_OUT)  output row
ch  out  max(1,clog2(CHANNEL))  channel index
addr00, addr01, addr10, addr11  out  ADDR_W each  source addresses (y0,x0),(y0,x1),(y1,x0),(y1,x1)
fx, fy  out  FRAC_W each  horizontal/vertical fractional weights
last  out  1  current request is the final one of the frame

Behaviour:
- Reset (rst low, async): state IDLE; all outputs, counters and accumulators 0.
- STEP_X = floor((W_IN<<FRAC_W)/W_OUT) and STEP_Y = floor((H_IN<<FRAC_W)/H_OUT) are elaboration-time constants.
- Source coordinates use incremental accumulators, no multipliers:
  - acc_x = 0 at each row start; acc_x += STEP_X when x_out advances.
  - acc_y likewise per row.
  - x0 = acc_x>>FRAC_W, fx = acc_x[FRAC_W-1:0], x1 = min(x0+1, W_IN-1); y identical with y0, y1, fy.
- Address formula: addr = (row*W_IN + col)*CHANNEL + ch, computed with registered constant-multiplied terms. All request outputs are registered.
- States:
  - IDLE: busy=0, req_valid=0. start=1 -> RUN; counters/accumulators cleared.
  - RUN:
    - req_valid=1 starting the cycle after start (latency 1).
    - Outputs hold stable while req_valid && !req_ready.
    - On handshake, next request presented the following cycle, so one request per cycle under continuous ready.
    - Advance order: ch; wrap at CHANNEL-1 -> x_out++; wrap at W_OUT-1 -> y_out++ and acc_x=0.
    - Handshake with last=1 -> DONE.
  - DONE: req_valid=0, done=1 for exactly one cycle -> IDLE. busy deasserts in the same cycle as done.
- last = (ch==CHANNEL-1 && x_out==W_OUT-1 && y_out==H_OUT-1).
- Total handshakes per frame = H_OUT*W_OUT*CHANNEL.
- start while RUN/DONE is ignored; start held high in IDLE starts exactly one frame per IDLE visit.
- Edge clamp applies at right and bottom borders; fx/fy are not zeroed there.
- Reset mid-frame aborts immediately with no done pulse; the next start begins at (0,0,0).

Optional Feature:
- Macro SCAN_PERF_EN.
- Defined:
  - Extra output port stall_cnt (32 bits): counts cycles with req_valid=1 && req_ready=0.
  - Cleared on accepted start, saturates at all-ones, held after done.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package bilinear_pkg:
  - state enum (IDLE, RUN, DONE)
  - STEP computation function
  - clog2-derived width constants shared with the datapath and top
- Natural sub-module: bilinear_axis_step, instantiated twice (x and y).
  - Contents: accumulator, integer/fraction split, clamp to size-1.
  - Ports: clear, advance, idx0, idx1, frac.

Test Plan:
- Config 4x4 -> 8x8, CHANNEL=1, FRAC_W=8 (STEP=128), ready tied high:
  - x_out=3, y_out=0 -> x0=1, x1=2, fx=128, addr00=1, addr11=6.
  - x_out=7 -> x0=x1=3 (clamp), addr10=addr11=7.
- Same config, count handshakes -> exactly 64; last on the 64th; done pulses one cycle later; busy falls with done.
- Backpressure: hold req_ready low 5 cycles mid-frame -> all request outputs stable; stall_cnt=5 with SCAN_PERF_EN.
- CHANNEL=3, 4x4 -> 8x8, request x_out=2, y_out=0 (x0=1, y0=0):
  - ch sequences 0,1,2 with addr00=3,4,5.
  - next request has x_out=3, ch=0.
- Reset low during 10th request -> outputs 0 immediately, no done. Then start -> first request x_out=0, y_out=0, ch=0. start pulsed during RUN -> frame length unchanged (64).
